// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states and RV32I load/store funct3 codes.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_e;

  localparam logic [F3_W-1:0] LB  = 3'b000;
  localparam logic [F3_W-1:0] LH  = 3'b001;
  localparam logic [F3_W-1:0] LW  = 3'b010;
  localparam logic [F3_W-1:0] LBU = 3'b100;
  localparam logic [F3_W-1:0] LHU = 3'b101;
  localparam logic [F3_W-1:0] SB  = 3'b000;
  localparam logic [F3_W-1:0] SH  = 3'b001;
  localparam logic [F3_W-1:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_align_check.sv
// Flags a load/store request as illegal: unsupported funct3 for its direction, or (optionally) a
// halfword/word access that is not naturally aligned.
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            write,
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      address,
  output logic            illegal
);

  logic bad_code;
  logic misaligned;

  always_comb begin
    bad_code = 1'b1;
    if (write) begin
      case (funct3)
        SB, SH, SW: bad_code = 1'b0;
        default:    bad_code = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB, LH, LW, LBU, LHU: bad_code = 1'b0;
        default:              bad_code = 1'b1;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal code.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = address[0];
      2'b10:   misaligned = (address != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal = bad_code | (ALIGN_CHECK & misaligned);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, issues it to data memory,
// captures load data one cycle later and holds the response until consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [F3_W-1:0] req_funct3,
  input  logic [XLEN-1:0] req_address,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            dmem_wren,
  output logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] dmem_address,
  output logic [XLEN-1:0] dmem_data_in,
  input  logic [XLEN-1:0] dmem_data_out
);

  lsu_state_e state;
  logic       write_q;
  logic       wren_q;
  logic       illegal;

  lsu_align_check #(
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_align_check (
    .write   (req_write),
    .funct3  (req_funct3),
    .address (req_address[1:0]),
    .illegal (illegal)
  );

  // Gated by reset so an aborted store never strobes memory, even mid-ISSUE.
  assign req_ready = (state == S_IDLE) & ~reset;
  assign dmem_wren = wren_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      write_q      <= 1'b0;
      wren_q       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_error    <= 1'b0;
      dmem_address <= '0;
      funct3       <= LW;
      dmem_data_in <= '0;
    end else begin
      wren_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q      <= req_write;
            dmem_address <= req_address;
            funct3       <= req_funct3;
            dmem_data_in <= req_wdata;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            if (illegal) begin
              rsp_error <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              wren_q <= req_write;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (write_q) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          rsp_rdata <= dmem_data_out;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (alignment checking on / off) share request inputs
// and are compared against a spec-level transaction model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;

  logic        req_ready     [2];
  logic        rsp_valid     [2];
  logic        rsp_ready     [2];
  logic [31:0] rsp_rdata     [2];
  logic        rsp_error     [2];
  logic        dmem_wren     [2];
  logic [2:0]  dmem_funct3   [2];
  logic [31:0] dmem_address  [2];
  logic [31:0] dmem_data_in  [2];
  logic [31:0] dmem_data_out [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ALIGN_CHECK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]), .dmem_wren(dmem_wren[0]),
    .funct3(dmem_funct3[0]), .dmem_address(dmem_address[0]),
    .dmem_data_in(dmem_data_in[0]), .dmem_data_out(dmem_data_out[0])
  );

  load_store_unit #(.ALIGN_CHECK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]), .dmem_wren(dmem_wren[1]),
    .funct3(dmem_funct3[1]), .dmem_address(dmem_address[1]),
    .dmem_data_in(dmem_data_in[1]), .dmem_data_out(dmem_data_out[1])
  );

  // Memory content is a fixed function of address and size; data appears the cycle after.
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f3);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ {29'd0, f3};
  endfunction

  always @(posedge clk) dmem_data_out[0] <= mem_rd(dmem_address[0], dmem_funct3[0]);
  always @(posedge clk) dmem_data_out[1] <= mem_rd(dmem_address[1], dmem_funct3[1]);

  function automatic bit model_err(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                   input bit align);
    bit legal;
    int unsigned size;
    legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 32'd1 << f3[1:0];
    return !legal || (align && ((a % size) != 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(req_ready[0] === 1'b1 && req_ready[1] === 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_timeout", 32'(guard >= 50), 32'd0);
  endtask

  // One request to both instances; per-instance expected latency/error, response held `hold` cycles.
  task automatic run_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int hold,
                         input int lat_a, input bit err_a, input int lat_b, input bit err_b);
    int lat [2], held [2], wcnt [2], wcyc [2];
    bit seen [2], done [2];
    logic [31:0] rd [2], waddr [2], wdat [2];
    logic er [2];
    logic [2:0] wf3 [2];
    int exp_lat [2];
    bit exp_err [2];
    exp_lat[0] = lat_a; exp_lat[1] = lat_b;
    exp_err[0] = err_a; exp_err[1] = err_b;
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; held[i] = 0; wcnt[i] = 0; wcyc[i] = 0; seen[i] = 0; done[i] = 0;
      rd[i] = '0; er[i] = 1'b0; waddr[i] = '0; wdat[i] = '0; wf3[i] = '0;
      rsp_ready[i] = 1'b0;
    end
    wait_idle();
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done[0] && done[1]) break;
      for (int i = 0; i < 2; i++) begin
        if (!done[i]) begin
          if (dmem_wren[i] === 1'b1) begin
            wcnt[i]++; wcyc[i] = cyc;
            waddr[i] = dmem_address[i]; wdat[i] = dmem_data_in[i]; wf3[i] = dmem_funct3[i];
          end
          chk($sformatf("busy_req_ready[%0d]", i), 32'(req_ready[i]), 32'd0);
          if (rsp_valid[i] === 1'b1) begin
            if (!seen[i]) begin
              seen[i] = 1'b1; lat[i] = cyc; rd[i] = rsp_rdata[i]; er[i] = rsp_error[i];
            end else begin
              chk($sformatf("hold_rdata[%0d]", i), rsp_rdata[i], rd[i]);
              chk($sformatf("hold_error[%0d]", i), 32'(rsp_error[i]), 32'(er[i]));
            end
            if (held[i] == hold) rsp_ready[i] = 1'b1;
            else held[i]++;
          end
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rsp_ready[i] === 1'b1) begin
          rsp_ready[i] = 1'b0;
          done[i] = 1'b1;
          chk($sformatf("rsp_valid_drop[%0d]", i), 32'(rsp_valid[i]), 32'd0);
          chk($sformatf("ready_after[%0d]", i), 32'(req_ready[i]), 32'd1);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp_timeout[%0d]", i), 32'(done[i]), 32'd1);
      chk($sformatf("latency[%0d] f3=%0d a=%h", i, f3, a), 32'(lat[i]), 32'(exp_lat[i]));
      chk($sformatf("rsp_error[%0d]", i), 32'(er[i]), 32'(exp_err[i]));
      chk($sformatf("rsp_rdata[%0d]", i), rd[i],
          (exp_err[i] || w) ? 32'd0 : mem_rd(a, f3));
      if (w && !exp_err[i]) begin
        chk($sformatf("wren_count[%0d]", i), 32'(wcnt[i]), 32'd1);
        chk($sformatf("wren_cycle[%0d]", i), 32'(wcyc[i]), 32'd1);
        chk($sformatf("wren_addr[%0d]", i), waddr[i], a);
        chk($sformatf("wren_data[%0d]", i), wdat[i], d);
        chk($sformatf("wren_f3[%0d]", i), 32'(wf3[i]), 32'(f3));
      end else begin
        chk($sformatf("no_wren[%0d]", i), 32'(wcnt[i]), 32'd0);
      end
    end
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    int          hold;
    int          lat_a;
    bit          err_a;
    int          lat_b;
    bit          err_b;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 3'b010, 32'h10, 32'h0,        0, 3, 0, 3, 0}; // LW -> DEADBEEF
    vecs[1]  = '{1, 3'b010, 32'h20, 32'h12345678, 0, 2, 0, 2, 0}; // SW
    vecs[2]  = '{0, 3'b001, 32'h03, 32'h0,        0, 1, 1, 3, 0}; // LH misaligned
    vecs[3]  = '{1, 3'b100, 32'h40, 32'h1,        0, 1, 1, 1, 1}; // store funct3 100
    vecs[4]  = '{0, 3'b011, 32'h44, 32'h0,        0, 1, 1, 1, 1}; // load funct3 011
    vecs[5]  = '{0, 3'b010, 32'h10, 32'h0,        5, 3, 0, 3, 0}; // LW back-pressured
    vecs[6]  = '{1, 3'b000, 32'h21, 32'hAB,       1, 2, 0, 2, 0}; // SB odd address
    vecs[7]  = '{0, 3'b101, 32'h02, 32'h0,        0, 3, 0, 3, 0}; // LHU aligned
    vecs[8]  = '{1, 3'b010, 32'h22, 32'h55AA55AA, 2, 1, 1, 2, 0}; // SW misaligned
    vecs[9]  = '{0, 3'b100, 32'h07, 32'h0,        2, 3, 0, 3, 0}; // LBU
    vecs[10] = '{1, 3'b111, 32'h30, 32'h9,        0, 1, 1, 1, 1}; // store funct3 111

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_address = '0; req_wdata = '0;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req_ready[%0d]", i), 32'(req_ready[i]), 32'd0);
      chk($sformatf("rst_rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", i), rsp_rdata[i], 32'd0);
      chk($sformatf("rst_error[%0d]", i), 32'(rsp_error[i]), 32'd0);
      chk($sformatf("rst_wren[%0d]", i), 32'(dmem_wren[i]), 32'd0);
      chk($sformatf("rst_addr[%0d]", i), dmem_address[i], 32'd0);
      chk($sformatf("rst_f3[%0d]", i), 32'(dmem_funct3[i]), 32'd2);
      chk($sformatf("rst_wdata[%0d]", i), dmem_data_in[i], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("post_rst_ready[%0d]", i), 32'(req_ready[i]), 32'd1);

    for (int v = 0; v < 11; v++)
      run_txn(vecs[v].w, vecs[v].f3, vecs[v].a, vecs[v].d, vecs[v].hold,
              vecs[v].lat_a, vecs[v].err_a, vecs[v].lat_b, vecs[v].err_b);

    // SB aborted by reset during its ISSUE cycle.
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_address = 32'h55; req_wdata = 32'hAB;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("abort_pre_wren[%0d]", i), 32'(dmem_wren[i]), 32'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_wren[%0d]", i), 32'(dmem_wren[i]), 32'd0);
      chk($sformatf("abort_ready[%0d]", i), 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_idle_ready[%0d]", i), 32'(req_ready[i]), 32'd1);
      chk($sformatf("abort_addr[%0d]", i), dmem_address[i], 32'd0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("abort_no_rsp[%0d]", i), 32'(rsp_valid[i]), 32'd0);
        chk($sformatf("abort_no_wren[%0d]", i), 32'(dmem_wren[i]), 32'd0);
      end
    end

    // Randomized requests against the model.
    for (int n = 0; n < 60; n++) begin
      bit w;
      logic [2:0] f3;
      logic [31:0] a, d;
      bit ea, eb;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      d  = $urandom;
      ea = model_err(w, f3, a, 1'b1);
      eb = model_err(w, f3, a, 1'b0);
      run_txn(w, f3, a, d, int'($urandom_range(0, 3)),
              ea ? 1 : (w ? 2 : 3), ea, eb ? 1 : (w ? 2 : 3), eb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ALIGN_CHECK, default 1, meaning 1 = misaligned/illegal requests are rejected with an error, 0 = alignment checking disabled (funct3 legality still checked).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I load/store funct3 (size, unsigned).
REQ-008 req_address  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  pipeline consumes the response.
REQ-012 rsp_rdata  output  32  load result as returned by memory (already extended); 0 for stores and errors.
REQ-013 rsp_error  output  1  request was misaligned or illegal; no memory access performed.
REQ-014 dmem_wren  output  1  memory write strobe.
REQ-015 funct3  output  3  size/sign code to memory.
REQ-016 dmem_address  output  32  memory byte address.
REQ-017 dmem_data_in  output  32  memory write data.
REQ-018 dmem_data_out  input  32  memory read data, valid the cycle after the address is sampled.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with reset low; handshake = req_valid & req_ready.
REQ-021 On handshake: request latched into holding registers; legal -> ISSUE, illegal -> RESP with rsp_error=1.
REQ-022 Legal loads: funct3 000, 001, 010, 100, 101; legal stores: 000, 001, 010; all others illegal.
REQ-023 With ALIGN_CHECK=1: halfword with address[0]=1 and word with address[1:0]!=00 are illegal.
REQ-024 dmem_address, funct3, dmem_data_in driven from holding registers; they hold their last values outside ISSUE.
REQ-025 dmem_wren = 1 only in ISSUE for a store, for exactly one cycle per store.
REQ-026 ISSUE: store -> RESP; load -> CAPTURE.
REQ-027 CAPTURE: dmem_data_out latched into rsp_rdata; -> RESP.
REQ-028 RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_ready; on rsp_ready -> IDLE, rsp_valid 0 next cycle.
REQ-029 Latency from handshake cycle T: load rsp_valid at T+3, store at T+2, error at T+1.
REQ-030 One outstanding request at most; no new request accepted before the response is consumed.
REQ-031 rsp_rdata and rsp_error cleared to 0 on each handshake; stores return rsp_rdata=0.
REQ-032 Back-pressure: rsp_ready held 0 for any number of cycles keeps RESP and data unchanged; no memory activity.

Reset
REQ-033 Reset SHALL force next state IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, dmem_address=0, funct3=3'b010, dmem_data_in=0.
REQ-034 dmem_wren SHALL be 0 in any cycle reset is high, including a store in ISSUE (store aborted).
REQ-035 Reset mid-transaction discards the transaction; no response is produced for it.

Structure
REQ-036 Package lsu_pkg SHALL hold the FSM state enum and funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-037 One combinational sub-module lsu_align_check (inputs write, funct3, address[1:0]; output illegal) SHALL implement REQ-022/023.

Verification
REQ-038 LW 0x00000010, memory returns 0xDEADBEEF -> rsp_valid at T+3, rsp_rdata=0xDEADBEEF, rsp_error=0, dmem_wren never high.
REQ-039 SW 0x00000020 data 0x12345678 -> dmem_wren high exactly at T+1 with address 0x20, data 0x12345678, funct3 010; rsp_valid at T+2, rsp_rdata=0.
REQ-040 LH 0x00000003 -> rsp_valid at T+1, rsp_error=1, no memory strobe; with ALIGN_CHECK=0 it issues normally.
REQ-041 Store funct3 100 -> rsp_error=1 at T+1; load funct3 011 -> rsp_error=1.
REQ-042 LW with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, accepted next request only after consumption.
REQ-043 SB issued, reset asserted in the ISSUE cycle -> dmem_wren=0, FSM IDLE next cycle, no rsp_valid, req_ready=1 once reset released.
